ikbd_serial_tx: RTL and testbench

Byte-to-8N1 serializer that produces the serial stream arriving on the ACIA `rx` pin. It is the keyboard/MIDI side of the link: the io controller pushes bytes, they are buffered in a small FIFO, and they are shifted out LSB-first at a fixed bit time. It is used at 7812.5 bps for the IKBD and at 31250 bps for MIDI, with no CPU register interface.

---
 rtl/ikbd_pkg.sv | 19 +
 rtl/byte_fifo.sv | 58 +++++
 rtl/ikbd_serial_tx.sv | 123 ++++++++++++
 tb/tb_ikbd_serial_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ikbd_pkg.sv
`default_nettype none
// ==========================================================================
// ikbd_pkg : shared FSM state type and bit-rate dividers for ikbd_serial_tx
// rev 1.0
// ==========================================================================
package ikbd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DIV_IKBD = 4096;  // 7812.5 bps at 32 MHz
  localparam int DIV_MIDI = 1024;  // 31250 bps at 32 MHz

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ==========================================================================
// byte_fifo : single-clock byte FIFO, head entry readable combinationally
// rev 1.0
// ==========================================================================
module byte_fifo
  import ikbd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ikbd_serial_tx.sv
`default_nettype none
// ==========================================================================
// ikbd_serial_tx : buffered byte-to-8N1 serializer feeding the ACIA rx pin
// rev 1.0
// ==========================================================================
module ikbd_serial_tx
  import ikbd_pkg::*;
#(
  parameter int CLK_DIV    = DIV_IKBD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_strobe,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);
  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     state;
  logic [15:0]   timer;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          empty;
  logic          stop_end;
  logic          pop;
  logic          bypass;

  assign stop_end = (state == STOP) && (timer == '0);
  assign pop      = !empty && ((state == IDLE) || stop_end);
  // A byte arriving on the very edge that ends STOP goes straight into the
  // shift register so the next frame still starts without an idle gap.
  assign bypass   = stop_end && empty && in_strobe;
  assign busy     = (state != IDLE) || (count != '0);

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (in_strobe && !bypass),
    .wr_data(in_data),
    .rd_en  (pop),
    .rd_data(head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (in_strobe && full) overflow <= 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= head;
            timer <= BIT_RELOAD;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (timer == '0) begin
            timer   <= BIT_RELOAD;
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (timer == '0) begin
            timer <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STOP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (pop || bypass) begin
            shift <= bypass ? in_data : head;
            timer <= BIT_RELOAD;
            tx    <= 1'b0;
            state <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ikbd_serial_tx.sv
`default_nettype none
// ==========================================================================
// tb_ikbd_serial_tx : scoreboard bench with a mid-bit sampling UART receiver
// rev 1.0
// ==========================================================================
module tb_ikbd_serial_tx;

  localparam int DIV   = 16;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_strobe = 1'b0;
  logic       full, busy, overflow, tx;

  logic [7:0] in_data2 = 8'h00;
  logic       in_strobe2 = 1'b0;
  logic       full2, busy2, overflow2, tx2;

  int         cyc = 0;
  int         frames = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  bit         rx_arm = 1'b1;
  logic [7:0] exp_q[$];
  int         starts[$];

  logic [7:0] rx_byte;
  logic       rx_sb, rx_eb;
  int         rx_st;

  ikbd_serial_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_strobe(in_strobe),
    .full(full), .busy(busy), .overflow(overflow), .tx(tx)
  );

  ikbd_serial_tx #(.CLK_DIV(4096), .FIFO_DEPTH(4)) dut_slow (
    .clk(clk), .reset(reset), .in_data(in_data2), .in_strobe(in_strobe2),
    .full(full2), .busy(busy2), .overflow(overflow2), .tx(tx2)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Receiver: start detected on the first low sample, then every bit sampled mid-cell.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_arm && tx === 1'b0) begin
        rx_st = cyc;
        repeat (DIV / 2) @(negedge clk);
        rx_sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          rx_byte[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        rx_eb = tx;
        if (rx_arm) begin
          starts.push_back(rx_st);
          frames++;
          check("start_bit", rx_sb, 1'b0);
          check("stop_bit", rx_eb, 1'b1);
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", rx_byte, exp_q.pop_front());
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit accepted);
    in_data   = b;
    in_strobe = 1'b1;
    if (accepted) exp_q.push_back(b);
    @(negedge clk);
    in_strobe = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames < n && t < budget) begin @(negedge clk); t++; end
    check("frames_arrived", frames >= n, 1);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin @(negedge clk); t++; end
    check("went_idle", busy, 1'b0);
  endtask

  task automatic wait_tx2(input logic lvl, input int budget, output int t);
    int n = 0;
    while (tx2 !== lvl && n < budget) begin @(negedge clk); n++; end
    check("slow_edge_seen", tx2 === lvl, 1);
    t = cyc;
  endtask

  initial begin
    int c0, s, base, lows, t0, t1, t2;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5
    base = frames;
    c0 = cyc;
    push(8'hA5, 1);
    wait_frames(base + 1, 400);
    check("single_start_latency", starts[base] - c0, 2);
    wait_until(starts[base] + FRAME - 1);
    check("busy_before_end", busy, 1'b1);
    @(negedge clk);
    check("busy_fall", busy, 1'b0);
    check("tx_idle_after", tx, 1'b1);

    // Back-to-back frames
    repeat (5) @(negedge clk);
    base = frames;
    c0 = cyc;
    push(8'h00, 1);
    push(8'hFF, 1);
    push(8'h3C, 1);
    wait_frames(base + 3, 4 * FRAME);
    check("b2b_start_latency", starts[base] - c0, 2);
    check("b2b_gap_1", starts[base + 1] - starts[base], FRAME);
    check("b2b_gap_2", starts[base + 2] - starts[base + 1], FRAME);
    wait_idle(2 * FRAME);

    // Overflow: 6 consecutive pushes, 5 accepted
    base = frames;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1);
    check("ovf_full_set", full, 1'b1);
    check("ovf_not_yet", overflow, 1'b0);
    push(8'hEE, 0);
    check("ovf_set", overflow, 1'b1);
    check("ovf_still_full", full, 1'b1);
    wait_frames(base + 5, 6 * FRAME);
    repeat (2 * FRAME) @(negedge clk);
    check("ovf_frame_count", frames - base, 5);
    check("ovf_idle", busy, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_queue_drained", exp_q.size(), 0);

    // Reset mid-frame during DATA bit 3 of 0x55
    rx_arm = 1'b0;
    c0 = cyc;
    push(8'h55, 0);
    s = c0 + 2;
    wait_until(s + DIV + 3 * DIV + 6);
    check("mid_bit3_value", tx, 1'b0);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_tx", tx, 1'b1);
    check("mrst_busy", busy, 1'b0);
    check("mrst_overflow", overflow, 1'b0);
    check("mrst_full", full, 1'b0);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("mrst_no_more_frames", lows, 0);
    rx_arm = 1'b1;

    // Late push on the STOP-ending edge of the previous frame
    base = frames;
    c0 = cyc;
    push(8'h11, 1);
    s = c0 + 2;
    wait_until(s + FRAME - 1);
    push(8'h81, 1);
    wait_frames(base + 2, 3 * FRAME);
    check("late_first_start", starts[base], s);
    check("late_gap", starts[base + 1] - starts[base], FRAME);
    check("late_queue_drained", exp_q.size(), 0);
    wait_idle(2 * FRAME);

    // Divider check at the IKBD rate, byte 0x01: bit0 high, bit1 low
    in_data2   = 8'h01;
    in_strobe2 = 1'b1;
    @(negedge clk);
    in_strobe2 = 1'b0;
    wait_tx2(1'b0, 10, t0);
    check("slow_busy", busy2, 1'b1);
    check("slow_full", full2, 1'b0);
    wait_tx2(1'b1, 5000, t1);
    wait_tx2(1'b0, 5000, t2);
    check("slow_start_bit_len", t1 - t0, 4096);
    check("slow_bit0_len", t2 - t1, 4096);
    check("slow_overflow", overflow2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
